arbitro_memoria: RTL
====================

# arbitro_memoria

Two-port arbiter and access sequencer for the Neander 256×8 data memory. The memory is organised as 16 banks of 16 words, and the block shares it between the CPU port and the program-loader port. For each granted request it runs one fixed-length memory cycle: it decodes the bank select from the address high nibble and returns read data with a single-cycle acknowledge. It sits between the CPU control unit / loader and the memory banks.

## Interface
- AW, 8, address width; the high 4 bits select the bank, the low 4 bits select the word.
- DW, 8, data width.
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- cpu_req  in  1  CPU request; held until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  AW  CPU address.
- cpu_wdata  in  DW  CPU write data.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_rdata  out  DW  registered CPU read data.
- ldr_req, ldr_we, ldr_addr, ldr_wdata, ldr_ack, ldr_rdata: loader port, identical to the CPU port.
- mem_en  out  16  one-hot bank enable.
- mem_addr  out  4  word within bank.
- mem_we  out  1  memory write strobe.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  read data from the enabled bank, valid in the cycle after the enable.

## Operation
- FSM states:
  - OCIOSO: waits for a request. If any request is pending, latch the winner, its we, addr and wdata, then go to ACESSO.
  - ACESSO: drives the memory for exactly one cycle, then goes to FIM.
  - FIM: for a read, captures mem_rdata into the winner's rdata register. Pulses the winner's ack, then returns to OCIOSO.
- Memory outputs in ACESSO:
  - mem_en = 1 << addr[7:4], one-hot, from the bank decoder.
  - mem_addr = addr[3:0]; mem_we = latched we; mem_wdata = latched wdata.
- Memory outputs outside ACESSO: mem_en = 0, mem_we = 0, mem_addr and mem_wdata = 0.
- Arbitration happens only in OCIOSO:
  - Only one requester active: that requester wins.
  - Both active: the winner is set by the policy in Configuration.
- Request latching: fields are sampled once, on entry to ACESSO. Changing or dropping req after grant does not abort the transaction; ack still pulses.
- Handshake:
  - A requester holding req high after its ack starts a new transaction; it competes again in the next OCIOSO cycle.
  - The requester must drop req in the cycle after ack to avoid a repeat.
- rdata registers:
  - Each port's rdata holds its last read value until that port's next read completes.
  - Writes and the other port's traffic leave it unchanged.
- Address boundaries: addr 0x00 gives bank 0, word 0; addr 0xFF gives bank 15, word 15. No wrap or carry logic.
- Reset, synchronous: state = OCIOSO, all ack = 0, all rdata = 0, mem_en = 0, mem_we = 0, last-grant = loader.
  - Reset during ACESSO or FIM aborts the transaction: no ack, no rdata update, mem_we low from the reset edge onward.

## Timing
- Request seen in OCIOSO on edge N: ACESSO during cycle N+1, FIM during N+2, ack high during N+2 only.
- rdata is valid from edge N+3 and stays valid.
- Throughput: one transaction per 3 cycles; back-to-back grants are possible with no idle cycle beyond OCIOSO.
- Worst-case wait with both requesters active continuously: 6 cycles under round-robin.
- The write reaches memory on the edge closing ACESSO (N+2 edge).

## Configuration
- ARBITRO_RR_EN defined: round-robin. With both requests active, the port not granted last wins; last-grant updates on each grant.
- ARBITRO_RR_EN undefined: fixed priority, CPU always wins. The loader is served only when cpu_req is low in OCIOSO, and the last-grant register is omitted.

## Structure
- The shared package `neander_mem_pkg` holds:
  - the state enum (OCIOSO, ACESSO, FIM);
  - the port-ID enum (PORTA_CPU, PORTA_LDR);
  - the constants N_BANCOS = 16 and PALAVRAS_BANCO = 16.
- Sub-module: the bank-select decoder is the existing `decod4x16`, instantiated once on the latched addr[7:4]. mem_en is its output gated by state == ACESSO.

## Test plan
- Reset, then a CPU write at addr 0x3A with data 0x5C: mem_en = 0x0008, mem_addr = 0xA, mem_we = 1 in cycle N+1; cpu_ack in N+2 only.
- CPU read at 0x3A with the memory model returning 0x5C: cpu_rdata = 0x5C from N+3; ldr_rdata stays 0x00.
- Simultaneous read requests with ARBITRO_RR_EN defined:
  - the CPU is served first, the loader next, alternating on every repeat;
  - without the macro, the CPU is served every time while cpu_req is held.
- Loader write at addr 0xFF: mem_en = 0x8000, mem_addr = 0xF. Addr 0x00: mem_en = 0x0001.
- Assert rst during ACESSO of a CPU write: mem_we = 0 and no cpu_ack follows; state is OCIOSO after release; all outputs are 0.
- Drop cpu_req one cycle after grant: cpu_ack still pulses once at N+2, and no second transaction starts.

Source files
------------

// File: rtl/neander_mem_pkg.sv
// Shared types and constants for the Neander 256x8 data memory.
// Used by arbitro_memoria and its bank decoder.
package neander_mem_pkg;

   localparam int N_BANCOS       = 16;
   localparam int PALAVRAS_BANCO = 16;

   typedef enum logic [1:0] {
      OCIOSO = 2'd0,
      ACESSO = 2'd1,
      FIM    = 2'd2
   } estado_t;

   typedef enum logic {
      PORTA_CPU = 1'b0,
      PORTA_LDR = 1'b1
   } porta_t;

endpackage

// File: rtl/arbitro_memoria_decod.sv
// decod4x16: 4-to-16 one-hot bank select decoder.
// Bit i of the output is set when the select equals i.
module decod4x16
   import neander_mem_pkg::*;
(
   input  logic [3:0]          i_sel,
   output logic [N_BANCOS-1:0] o_onehot
);

   // one-hot decode of the bank number
   always_comb begin
      o_onehot        = '0;
      o_onehot[i_sel] = 1'b1;
   end

endmodule

// File: rtl/arbitro_memoria.sv
// arbitro_memoria: CPU/loader arbiter and 3-cycle access sequencer.
// Define ARBITRO_RR_EN for round-robin; otherwise the CPU has fixed priority.
module arbitro_memoria
   import neander_mem_pkg::*;
#(
   parameter int AW = 8,
   parameter int DW = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                cpu_req,
   input  logic                cpu_we,
   input  logic [AW-1:0]       cpu_addr,
   input  logic [DW-1:0]       cpu_wdata,
   output logic                cpu_ack,
   output logic [DW-1:0]       cpu_rdata,
   input  logic                ldr_req,
   input  logic                ldr_we,
   input  logic [AW-1:0]       ldr_addr,
   input  logic [DW-1:0]       ldr_wdata,
   output logic                ldr_ack,
   output logic [DW-1:0]       ldr_rdata,
   output logic [N_BANCOS-1:0] mem_en,
   output logic [3:0]          mem_addr,
   output logic                mem_we,
   output logic [DW-1:0]       mem_wdata,
   input  logic [DW-1:0]       mem_rdata
);

   estado_t             r_estado;
   estado_t             w_prox;
   porta_t              r_porta;
   logic                r_we;
   logic [AW-1:0]       r_addr;
   logic [DW-1:0]       r_wdata;
   logic [DW-1:0]       r_cpu_rdata;
   logic [DW-1:0]       r_ldr_rdata;
   porta_t              w_venc;
   logic                w_algum;
   logic                w_concede;
   logic                w_acesso;
   logic                w_fim;
   logic [N_BANCOS-1:0] w_dec;

   assign w_algum = cpu_req | ldr_req;

`ifdef ARBITRO_RR_EN
   porta_t r_ultimo;

   // remember which port got the last grant
   always_ff @(posedge clk) begin
      if (rst)
         r_ultimo <= PORTA_LDR;
      else if (w_concede)
         r_ultimo <= w_venc;
   end

   // on contention the port not served last wins
   always_comb begin
      w_venc = PORTA_CPU;
      if (cpu_req && ldr_req)
         w_venc = (r_ultimo == PORTA_CPU) ? PORTA_LDR : PORTA_CPU;
      else if (ldr_req)
         w_venc = PORTA_LDR;
   end
`else
   // CPU always wins; loader only when the CPU is idle
   always_comb begin
      w_venc = PORTA_CPU;
      if (!cpu_req && ldr_req)
         w_venc = PORTA_LDR;
   end
`endif

   // state register
   always_ff @(posedge clk) begin
      if (rst)
         r_estado <= OCIOSO;
      else
         r_estado <= w_prox;
   end

   // next state and phase strobes
   always_comb begin
      w_prox    = r_estado;
      w_concede = 1'b0;
      w_acesso  = 1'b0;
      w_fim     = 1'b0;
      unique case (r_estado)
         OCIOSO: begin
            if (w_algum) begin
               w_concede = 1'b1;
               w_prox    = ACESSO;
            end
         end
         ACESSO: begin
            w_acesso = 1'b1;
            w_prox   = FIM;
         end
         FIM: begin
            w_fim  = 1'b1;
            w_prox = OCIOSO;
         end
         default: w_prox = OCIOSO;
      endcase
   end

   // sample the winner's request fields once, at grant
   always_ff @(posedge clk) begin
      if (rst) begin
         r_porta <= PORTA_CPU;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
      end else if (w_concede) begin
         r_porta <= w_venc;
         if (w_venc == PORTA_CPU) begin
            r_we    <= cpu_we;
            r_addr  <= cpu_addr;
            r_wdata <= cpu_wdata;
         end else begin
            r_we    <= ldr_we;
            r_addr  <= ldr_addr;
            r_wdata <= ldr_wdata;
         end
      end
   end

   // capture read data into the winner's register at end of FIM
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cpu_rdata <= '0;
         r_ldr_rdata <= '0;
      end else if (w_fim && !r_we) begin
         if (r_porta == PORTA_CPU)
            r_cpu_rdata <= mem_rdata;
         else
            r_ldr_rdata <= mem_rdata;
      end
   end

   decod4x16 u_decod (
      .i_sel    (r_addr[AW-1:AW-4]),
      .o_onehot (w_dec)
   );

   assign mem_en    = w_acesso ? w_dec : '0;
   assign mem_addr  = w_acesso ? r_addr[3:0] : 4'h0;
   assign mem_we    = w_acesso & r_we;
   assign mem_wdata = w_acesso ? r_wdata : '0;

   // a reset during FIM suppresses the acknowledge
   assign cpu_ack   = w_fim & ~rst & (r_porta == PORTA_CPU);
   assign ldr_ack   = w_fim & ~rst & (r_porta == PORTA_LDR);
   assign cpu_rdata = r_cpu_rdata;
   assign ldr_rdata = r_ldr_rdata;

endmodule
